// File: rtl/uart_rx.sv
// Asynchronous-line UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// parallel word output with one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int data_len = 15,
  parameter int clk_div  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_in,
  output logic [data_len-1:0] data_out,
  output logic                data_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int CW = $clog2(clk_div);
  localparam int BW = $clog2(data_len);
  localparam int H  = clk_div / 2;

  localparam logic [CW-1:0] HALF_M1 = CW'(H - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(clk_div - 1);
  localparam logic [BW-1:0] LAST    = BW'(data_len - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sync1, r_sync2;
  logic [CW-1:0]       r_clk_cnt, w_clk_nxt;
  logic [BW-1:0]       r_bit_cnt, w_bit_nxt;
  logic [data_len-1:0] r_shift, w_shift_nxt;
  logic [data_len-1:0] r_data, w_data_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_err, w_err_nxt;
  logic                w_rx_s;

  assign w_rx_s = r_sync2;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clk_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_clk_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == BIT_M1) begin
          w_clk_nxt              = '0;
          w_shift_nxt[r_bit_cnt] = w_rx_s;
          if (r_bit_cnt == LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == BIT_M1) begin
          w_clk_nxt = '0;
          if (w_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a break is not seen as start bits.
        w_clk_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sync1   <= rx_in;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8-bit/16-div instance for directed cases and a
// default-parameter instance fed by a bench-side transmitter model.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_a, rx_b;
  logic [7:0]  data_out_a;
  logic [14:0] data_out_b;
  logic        data_valid_a, frame_err_a, busy_a;
  logic        data_valid_b, frame_err_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t_fall = 0;
  int n_valid_a = 0, n_valid_b = 0;
  int n_err_a = 0, n_err_b = 0;
  logic timing_on = 1'b0;
  logic prev_valid_a = 1'b0, prev_valid_b = 1'b0;
  logic [14:0] q_a[$];
  logic [14:0] q_b[$];

  uart_rx #(.data_len(8), .clk_div(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_a),
    .data_out(data_out_a), .data_valid(data_valid_a),
    .frame_err(frame_err_a), .busy(busy_a)
  );

  uart_rx u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_b),
    .data_out(data_out_b), .data_valid(data_valid_b),
    .frame_err(frame_err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // Transmitter model: start, LSB-first data, stop; each bit lasts div cycles.
  task automatic send_frame(input int sel, input logic [14:0] data, input int len,
                            input int div, input logic stop_bit);
    @(posedge clk); #1;
    if (stop_bit) begin
      if (sel == 0) q_a.push_back(data);
      else          q_b.push_back(data);
    end
    if (sel == 0) t_fall = cyc;
    set_line(sel, 1'b0);
    repeat (div) @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      set_line(sel, data[i]);
      repeat (div) @(posedge clk);
      #1;
    end
    set_line(sel, stop_bit);
    repeat (div) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel == 0 ? q_a.size() : q_b.size()) == 0) break;
      @(negedge clk);
    end
    check(sel == 0 ? "a_drain_timeout" : "b_drain_timeout",
          sel == 0 ? q_a.size() : q_b.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (data_valid_a && frame_err_a) check("a_valid_err_overlap", 1, 0);
    if (data_valid_a && prev_valid_a) check("a_valid_double", 1, 0);
    if (data_valid_a) begin
      n_valid_a++;
      if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        check("a_data", {24'd0, data_out_a}, {17'd0, q_a.pop_front()});
        if (timing_on) check("a_valid_latency", cyc - t_fall, 155);
      end
    end
    if (frame_err_a) n_err_a++;
    prev_valid_a = data_valid_a;

    if (data_valid_b && frame_err_b) check("b_valid_err_overlap", 1, 0);
    if (data_valid_b && prev_valid_b) check("b_valid_double", 1, 0);
    if (data_valid_b) begin
      n_valid_b++;
      if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
      else check("b_data", {17'd0, data_out_b}, {17'd0, q_b.pop_front()});
    end
    if (frame_err_b) n_err_b++;
    prev_valid_b = data_valid_b;
  end

  initial begin
    logic saw_busy;
    logic [7:0] mf;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_data_out", {24'd0, data_out_a}, 0);
    check("rst_data_valid", data_valid_a, 0);
    check("rst_frame_err", frame_err_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_b_busy", busy_b, 0);

    // Single frame with latency check
    timing_on = 1'b1;
    send_frame(0, 15'h00A5, 8, 16, 1'b1);
    wait_drain(0, 100);
    timing_on = 1'b0;
    check("a5_valid_count", n_valid_a, 1);
    check("a5_data_out", {24'd0, data_out_a}, 32'hA5);
    check("a5_busy_after", busy_a, 0);
    check("a5_no_err", n_err_a, 0);

    // Glitch shorter than half a bit
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_a = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy_a) saw_busy = 1'b1;
    end
    check("glitch_busy_rose", saw_busy, 1);
    check("glitch_busy_back", busy_a, 0);
    check("glitch_valid_count", n_valid_a, 1);
    check("glitch_err_count", n_err_a, 0);
    check("glitch_data_kept", {24'd0, data_out_a}, 32'hA5);

    // Framing error, held break, then good frame
    send_frame(0, 15'h003C, 8, 16, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("break_busy_held", busy_a, 1);
    check("break_err_count", n_err_a, 1);
    check("break_data_kept", {24'd0, data_out_a}, 32'hA5);
    rx_a = 1'b1;
    repeat (6) @(negedge clk);
    check("break_released", busy_a, 0);
    send_frame(0, 15'h00C3, 8, 16, 1'b1);
    wait_drain(0, 100);
    check("c3_data_out", {24'd0, data_out_a}, 32'hC3);
    check("c3_err_count", n_err_a, 1);

    // Default-parameter loopback, back-to-back frames
    send_frame(1, 15'h5A5A, 15, 100, 1'b1);
    send_frame(1, 15'h7FFF, 15, 100, 1'b1);
    wait_drain(1, 300);
    check("b_valid_count", n_valid_b, 2);
    check("b_err_count", n_err_b, 0);
    check("b_data_last", {17'd0, data_out_b}, 32'h7FFF);

    // Reset during data bit 3
    mf = 8'h55;
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 rx_a = mf[i];
      repeat (16) @(posedge clk);
    end
    #1 rx_a = mf[3];
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_data_out", {24'd0, data_out_a}, 0);
    check("mid_rst_valid_count", n_valid_a, 2);
    send_frame(0, 15'h0081, 8, 16, 1'b1);
    wait_drain(0, 100);
    check("81_data_out", {24'd0, data_out_a}, 32'h81);
    check("final_valid_count", n_valid_a, 3);
    check("final_err_count", n_err_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of uart_tx and consumes its tx_op line.
- Frame format matches uart_tx exactly:
  - 1 start bit (low).
  - data_len data bits, LSB (index 0) first.
  - 1 stop bit (high).
  - Every bit lasts clk_div clock cycles.
- Recovers each word, presents it in parallel with a one-cycle valid strobe, and flags framing errors.

Parameters:
data_len, 15, data bits per frame (must be >= 2); must equal the uart_tx setting.
clk_div, 100, clock cycles per bit (must be >= 4); must equal the uart_tx setting.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
rx_in  input  1  serial line (uart_tx tx_op); asynchronous to clk; idles high.
data_out  output  data_len  last correctly received word, bit 0 = first data bit on line.
data_valid  output  1  one-cycle pulse: data_out updated with a new good word.
frame_err  output  1  one-cycle pulse: stop bit sampled low; word discarded.
busy  output  1  high whenever FSM is not in S_IDLE.

Behaviour:
- Reset (rst_n low at a rising edge, any state, including mid-frame):
  - FSM goes to S_IDLE; clk_cnt = 0, bit_cnt = 0, shift register = 0.
  - data_out = 0, data_valid = 0, frame_err = 0, busy = 0.
  - Both synchroniser flops are set to 1.
- Synchroniser: rx_in passes through 2 flops to give rx_s. The FSM uses only rx_s, which adds 2 cycles of latency.
- Counter widths:
  - clk_cnt is $clog2(clk_div) bits and wraps only by explicit clear.
  - bit_cnt is $clog2(data_len) bits.
- Let h = clk_div/2 (integer division).
- S_IDLE:
  - Counters held at 0.
  - rx_s == 0 -> S_START, clk_cnt = 0. Call this edge N0.
- S_START:
  - clk_cnt increments each cycle.
  - When clk_cnt == h-1 (edge N0+h), sample rx_s:
    - rx_s == 0 -> S_DATA, clk_cnt = 0.
    - rx_s == 1 -> S_IDLE (glitch rejected, no strobe).
- S_DATA:
  - clk_cnt increments each cycle.
  - When clk_cnt == clk_div-1:
    - Store rx_s into shift[bit_cnt] and clear clk_cnt.
    - If bit_cnt == data_len-1: bit_cnt = 0, go to S_STOP; otherwise bit_cnt + 1.
  - Data bit k is sampled at edge N0 + h + (k+1)*clk_div.
- S_STOP:
  - When clk_cnt == clk_div-1 (edge Ns = N0 + h + (data_len+1)*clk_div), sample rx_s:
    - rx_s == 1: data_out <= shift; data_valid high for the one cycle after Ns; go to S_IDLE.
    - rx_s == 0: frame_err high for the one cycle after Ns; data_out unchanged; go to S_BREAK.
- S_BREAK:
  - Wait until rx_s == 1, then S_IDLE.
  - This prevents a held-low line (break) from being read as new start bits.
- Back-to-back frames: returning to S_IDLE at mid-stop-bit lets the next start edge be caught with no gap required beyond the stop bit.
- data_valid and frame_err are never high together and never high for 2 consecutive cycles from a single frame.
- busy is a combinational decode: state != S_IDLE.
- No output depends combinationally on rx_in.

Test Plan:
- Reset values: data_len=8, clk_div=16. Hold rst_n low 5 cycles with rx_in=1, then release.
  - Required: data_out=0, data_valid=0, frame_err=0, busy=0.
- Single frame: drive 8'hA5 (start, bits 1,0,1,0,0,1,0,1, stop).
  - Required: exactly one data_valid pulse, data_out=8'hA5, frame_err never high, busy drops the cycle after the pulse.
  - Pulse timing: within +-1 cycle of 2 + 8 + 9*16 cycles after the rx_in falling edge.
- Glitch rejection: rx_in low for 4 cycles, then high.
  - Required: busy rises, then FSM returns to S_IDLE after the mid-start check.
  - Required: no data_valid or frame_err pulse; data_out unchanged.
- Framing error: send 8'h3C with the stop bit driven low, keep line low 40 cycles, then high, then send 8'hC3 normally.
  - Required: one frame_err pulse; data_out stays at its prior value.
  - Required: no restart while low; then data_valid with data_out=8'hC3.
- Loopback: instantiate uart_tx and uart_rx with defaults (15, 100), tx_op to rx_in. Send 15'h5A5A then immediately 15'h7FFF.
  - Required: two data_valid pulses, with data_out 15'h5A5A then 15'h7FFF, and no frame_err.
- Reset mid-frame: assert rst_n low during data bit 3 of a frame, release, then send 8'h81.
  - Required: no pulse from the aborted frame, and one data_valid with data_out=8'h81.
